// File: rtl/main_memory_responder_pkg.sv
// Shared types and defaults for the main memory responder (request format, FSM states, helpers).
package main_memory_responder_pkg;

   localparam int LINE_W          = 128;   // icache and dcache lines are both 16 bytes
   localparam int MEM_LINES_DEF   = 4096;
   localparam int MEM_LATENCY_DEF = 10;
   localparam int LINE_BYTES_DEF  = 16;

   typedef struct packed {
      logic [31:0]       addr;
      logic              is_store;
      logic [LINE_W-1:0] data;
   } memory_request_t;

   typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mem_rsp_state_t;

   typedef enum logic {PORT_IC = 1'b0, PORT_DC = 1'b1} mem_port_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/main_memory_array.sv
// Line-organised backing store: one synchronous read/write port, read data registered.
module main_memory_array #(
   parameter int LINES = 4096,
   parameter int WIDTH = 128,
   localparam int AW   = $clog2(LINES)
) (
   input  logic             clock,
   input  logic             en,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [LINES];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clock) begin
      if (en) begin
         if (we) mem_q[addr] <= wdata;
         else    rdata_q     <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// Memory-side end of the icache/dcache miss interface: two pending slots, round-robin grant,
// fixed-latency access FSM. Optional MEM_RSP_STATS_EN adds load/store/error counters.
module main_memory_responder
   import main_memory_responder_pkg::*;
#(
   parameter int MEM_LINES   = MEM_LINES_DEF,
   parameter int MEM_LATENCY = MEM_LATENCY_DEF,
   parameter int LINE_BYTES  = LINE_BYTES_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ic_req_valid,
   input  memory_request_t   ic_req_info,
   output logic              ic_rsp_valid,
   output logic [LINE_W-1:0] ic_rsp_data,
   output logic              ic_rsp_bus_error,
   input  logic              dc_req_valid,
   input  memory_request_t   dc_req_info,
   output logic              dc_rsp_valid,
   output logic [LINE_W-1:0] dc_rsp_data,
   output logic              dc_rsp_bus_error,
   output logic              busy
`ifdef MEM_RSP_STATS_EN
   ,
   output logic [31:0]       stat_loads,
   output logic [31:0]       stat_stores,
   output logic [31:0]       stat_errors
`endif
);

   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int AW    = $clog2(MEM_LINES);
   localparam int CNT_W = $clog2(MEM_LATENCY + 1);

   mem_rsp_state_t    state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   mem_port_t         gnt_q, gnt_d;
   mem_port_t         rr_last_q, rr_last_d;
   logic              ic_pend_q, ic_pend_d, dc_pend_q, dc_pend_d;
   memory_request_t   ic_info_q, ic_info_d, dc_info_q, dc_info_d;

   memory_request_t   cur_info;
   logic [31:0]       line_idx;
   logic              addr_err, access, rsp, mem_en;
   logic [LINE_W-1:0] mem_rdata, rsp_data;
   logic              ic_drop, dc_drop;

   main_memory_array #(.LINES(MEM_LINES), .WIDTH(LINE_W)) u_mem (
      .clock (clock),
      .en    (mem_en),
      .we    (cur_info.is_store),
      .addr  (line_idx[AW-1:0]),
      .wdata (cur_info.data),
      .rdata (mem_rdata)
   );

   // The granted slot stays pending until RESP, so it doubles as the in-flight request.
   always_comb begin
      cur_info = (gnt_q == PORT_DC) ? dc_info_q : ic_info_q;
      line_idx = cur_info.addr >> OFF_W;
      addr_err = (line_idx >= 32'(MEM_LINES));
      access   = (state_q == MEM_WAIT) && (cnt_q == '0);
      mem_en   = access && !addr_err;
      rsp      = (state_q == MEM_RESP);
      rsp_data = (rsp && !addr_err && !cur_info.is_store) ? mem_rdata : '0;
   end

   assign ic_rsp_valid     = rsp && (gnt_q == PORT_IC);
   assign dc_rsp_valid     = rsp && (gnt_q == PORT_DC);
   assign ic_rsp_data      = (gnt_q == PORT_IC) ? rsp_data : '0;
   assign dc_rsp_data      = (gnt_q == PORT_DC) ? rsp_data : '0;
   assign ic_rsp_bus_error = ic_rsp_valid && addr_err;
   assign dc_rsp_bus_error = dc_rsp_valid && addr_err;
   assign busy             = (state_q != MEM_IDLE) || ic_pend_q || dc_pend_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      rr_last_d = rr_last_q;
      ic_pend_d = ic_pend_q;
      dc_pend_d = dc_pend_q;
      ic_info_d = ic_info_q;
      dc_info_d = dc_info_q;
      case (state_q)
         MEM_IDLE: begin
            if (ic_pend_q || dc_pend_q) begin
               state_d = MEM_WAIT;
               cnt_d   = CNT_W'(MEM_LATENCY - 1);
               if (ic_pend_q && dc_pend_q)
                  gnt_d = (rr_last_q == PORT_DC) ? PORT_IC : PORT_DC;
               else
                  gnt_d = ic_pend_q ? PORT_IC : PORT_DC;
            end
         end
         MEM_WAIT: begin
            if (cnt_q == '0) state_d = MEM_RESP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         MEM_RESP: begin
            state_d   = MEM_IDLE;
            rr_last_d = gnt_q;
            if (gnt_q == PORT_IC) ic_pend_d = 1'b0;
            else                  dc_pend_d = 1'b0;
         end
         default: state_d = MEM_IDLE;
      endcase
      // Capture after the RESP clear so a pulse in the clearing cycle replaces the old info.
      if (ic_req_valid && !ic_pend_d) begin
         ic_pend_d = 1'b1;
         ic_info_d = ic_req_info;
      end
      if (dc_req_valid && !dc_pend_d) begin
         dc_pend_d = 1'b1;
         dc_info_d = dc_req_info;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= MEM_IDLE;
         cnt_q     <= '0;
         gnt_q     <= PORT_IC;
         rr_last_q <= PORT_DC;
         ic_pend_q <= 1'b0;
         dc_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         rr_last_q <= rr_last_d;
         ic_pend_q <= ic_pend_d;
         dc_pend_q <= dc_pend_d;
      end
   end

   always_ff @(posedge clock) begin
      ic_info_q <= ic_info_d;
      dc_info_q <= dc_info_d;
   end

   assign ic_drop = ic_req_valid && ic_pend_q && !(rsp && gnt_q == PORT_IC);
   assign dc_drop = dc_req_valid && dc_pend_q && !(rsp && gnt_q == PORT_DC);

   a_ic_no_drop: assert property (@(posedge clock) disable iff (!reset_n) !ic_drop);
   a_dc_no_drop: assert property (@(posedge clock) disable iff (!reset_n) !dc_drop);

`ifdef MEM_RSP_STATS_EN
   logic [31:0] loads_q, loads_d, stores_q, stores_d, errors_q, errors_d;

   always_comb begin
      loads_d  = loads_q;
      stores_d = stores_q;
      errors_d = errors_q;
      if (rsp) begin
         if (addr_err)               errors_d = sat_inc32(errors_q);
         else if (cur_info.is_store) stores_d = sat_inc32(stores_q);
         else                        loads_d  = sat_inc32(loads_q);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         loads_q  <= '0;
         stores_q <= '0;
         errors_q <= '0;
      end else begin
         loads_q  <= loads_d;
         stores_q <= stores_d;
         errors_q <= errors_d;
      end
   end

   assign stat_loads  = loads_q;
   assign stat_stores = stores_q;
   assign stat_errors = errors_q;
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder: directed requests push expected responses,
// a negedge monitor pops and compares. Build with MEM_RSP_STATS_EN to also check counters.
module tb_main_memory_responder;
   import main_memory_responder_pkg::*;

   localparam int L = 10;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              ic_req_valid = 1'b0, dc_req_valid = 1'b0;
   memory_request_t   ic_req_info = '0, dc_req_info = '0;
   logic              ic_rsp_valid, dc_rsp_valid, ic_rsp_bus_error, dc_rsp_bus_error, busy;
   logic [LINE_W-1:0] ic_rsp_data, dc_rsp_data;
`ifdef MEM_RSP_STATS_EN
   logic [31:0]       stat_loads, stat_stores, stat_errors;
`endif

   main_memory_responder #(.MEM_LINES(4096), .MEM_LATENCY(L), .LINE_BYTES(16)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .ic_req_valid     (ic_req_valid),
      .ic_req_info      (ic_req_info),
      .ic_rsp_valid     (ic_rsp_valid),
      .ic_rsp_data      (ic_rsp_data),
      .ic_rsp_bus_error (ic_rsp_bus_error),
      .dc_req_valid     (dc_req_valid),
      .dc_req_info      (dc_req_info),
      .dc_rsp_valid     (dc_rsp_valid),
      .dc_rsp_data      (dc_rsp_data),
      .dc_rsp_bus_error (dc_rsp_bus_error),
      .busy             (busy)
`ifdef MEM_RSP_STATS_EN
      ,
      .stat_loads       (stat_loads),
      .stat_stores      (stat_stores),
      .stat_errors      (stat_errors)
`endif
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [LINE_W-1:0] data;
      logic              err;
      int                at;   // expected cycle, -1 = not checked
   } exp_t;

   exp_t ic_q[$];
   exp_t dc_q[$];

   localparam logic [LINE_W-1:0] PAT_A5 = {16{8'hA5}};
   localparam logic [LINE_W-1:0] PAT_12 = {8{16'h1234}};
   localparam logic [LINE_W-1:0] PAT_C3 = {16{8'hC3}};
   localparam logic [LINE_W-1:0] PAT_5A = {16{8'h5A}};
   localparam logic [LINE_W-1:0] PAT_77 = {16{8'h77}};
   localparam logic [LINE_W-1:0] PAT_FF = {16{8'hFF}};

   task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic cmp_rsp(input string nm, input exp_t e, input logic [LINE_W-1:0] d, input logic err);
      chk({nm, "_data"}, d, e.data);
      chk({nm, "_bus_error"}, LINE_W'(err), LINE_W'(e.err));
      if (e.at >= 0) chk({nm, "_cycle"}, LINE_W'(cyc), LINE_W'(e.at));
   endtask

   always @(negedge clock) begin
      if (ic_rsp_valid && dc_rsp_valid) begin
         total++; bad++;
         $display("FAIL both_rsp_valid: got 1 expected 0 (cycle %0d)", cyc);
      end
      if (ic_rsp_valid) begin
         if (ic_q.size() == 0) begin
            total++; bad++;
            $display("FAIL ic_unexpected_rsp: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
         end else cmp_rsp("ic", ic_q.pop_front(), ic_rsp_data, ic_rsp_bus_error);
      end
      if (dc_rsp_valid) begin
         if (dc_q.size() == 0) begin
            total++; bad++;
            $display("FAIL dc_unexpected_rsp: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
         end else cmp_rsp("dc", dc_q.pop_front(), dc_rsp_data, dc_rsp_bus_error);
      end
   end

   task automatic expect_rsp(input bit to_dc, input logic [LINE_W-1:0] d, input logic e, input int at);
      exp_t x;
      x.data = d; x.err = e; x.at = at;
      if (to_dc) dc_q.push_back(x);
      else       ic_q.push_back(x);
   endtask

   // Called at posedge+1; pulse is captured by the following posedge.
   task automatic drive(input bit iv, input memory_request_t ii, input bit dv, input memory_request_t di);
      ic_req_valid = iv; ic_req_info = ii;
      dc_req_valid = dv; dc_req_info = di;
      @(posedge clock); #1;
      ic_req_valid = 1'b0;
      dc_req_valid = 1'b0;
   endtask

   function automatic memory_request_t mk(input logic [31:0] a, input logic st, input logic [LINE_W-1:0] d);
      memory_request_t r;
      r.addr = a; r.is_store = st; r.data = d;
      return r;
   endfunction

   // Lone request from idle: response L+2 cycles after the drive cycle.
   task automatic req(input bit to_dc, input logic [31:0] a, input logic st, input logic [LINE_W-1:0] d,
                      input logic [LINE_W-1:0] ed, input logic ee);
      expect_rsp(to_dc, ed, ee, cyc + L + 2);
      if (to_dc) drive(1'b0, '0, 1'b1, mk(a, st, d));
      else       drive(1'b1, mk(a, st, d), 1'b0, '0);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 300; i++) begin
         if (ic_q.size() == 0 && dc_q.size() == 0 && !busy) return;
         @(posedge clock); #1;
      end
      total++; bad++;
      $display("FAIL wait_done_timeout: got %0d/%0d pending expected 0/0", ic_q.size(), dc_q.size());
      ic_q.delete();
      dc_q.delete();
   endtask

   task automatic chk_idle_outputs(input string nm);
      chk({nm, "_ic_valid"}, LINE_W'(ic_rsp_valid), '0);
      chk({nm, "_dc_valid"}, LINE_W'(dc_rsp_valid), '0);
      chk({nm, "_ic_data"}, ic_rsp_data, '0);
      chk({nm, "_dc_data"}, dc_rsp_data, '0);
      chk({nm, "_busy"}, LINE_W'(busy), '0);
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1 chk_idle_outputs("reset");
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int k, t;
      repeat (3) @(posedge clock);
      #1 chk_idle_outputs("por");
      reset_n = 1'b1;
      @(posedge clock); #1;

      // Preload line 4, then load it back with exact latency.
      req(1'b1, 32'h0040, 1'b1, PAT_A5, '0, 1'b0); wait_done();
      req(1'b1, 32'h0040, 1'b0, '0, PAT_A5, 1'b0); wait_done();

      // Store ack then load of the written line; offset bits ignored on the load.
      req(1'b1, 32'h0080, 1'b1, PAT_12, '0, 1'b0); wait_done();
      req(1'b1, 32'h008C, 1'b0, '0, PAT_12, 1'b0); wait_done();

      // Simultaneous pulses straight out of reset: IC first, DC L+2 cycles later.
      do_reset();
      k = cyc;
      expect_rsp(1'b0, PAT_A5, 1'b0, k + L + 2);
      expect_rsp(1'b1, PAT_12, 1'b0, k + 2 * L + 4);
      drive(1'b1, mk(32'h0040, 1'b0, '0), 1'b1, mk(32'h0080, 1'b0, '0));
      wait_done();

      // Reset during WAIT of a store: no response, line keeps its old contents.
      req(1'b1, 32'h00C0, 1'b1, PAT_5A, '0, 1'b0); wait_done();
      drive(1'b0, '0, 1'b1, mk(32'h00C0, 1'b1, PAT_77));
      repeat (4) begin @(posedge clock); #1; end
      do_reset();
      repeat (L + 5) begin @(posedge clock); #1; end
      req(1'b1, 32'h00C0, 1'b0, '0, PAT_5A, 1'b0); wait_done();

      // Out-of-range line: error on load and store, store must not alias onto line 0.
      req(1'b1, 32'h0000, 1'b1, PAT_C3, '0, 1'b0); wait_done();
      req(1'b1, 32'h0001_0000, 1'b0, '0, '0, 1'b1); wait_done();
      req(1'b1, 32'h0001_0000, 1'b1, PAT_FF, '0, 1'b1); wait_done();
      req(1'b0, 32'h0001_0000, 1'b0, '0, '0, 1'b1); wait_done();
      req(1'b1, 32'h0000, 1'b0, '0, PAT_C3, 1'b0); wait_done();

      // New IC pulse in the same cycle its RESP clears the slot is captured and served.
      k = cyc;
      t = k + L + 2;
      req(1'b0, 32'h0040, 1'b0, '0, PAT_A5, 1'b0);
      while (cyc < t) begin @(posedge clock); #1; end
      req(1'b0, 32'h0080, 1'b0, '0, PAT_12, 1'b0);
      wait_done();

`ifdef MEM_RSP_STATS_EN
      chk("stat_loads",  LINE_W'(stat_loads),  LINE_W'(4));
      chk("stat_stores", LINE_W'(stat_stores), LINE_W'(1));
      chk("stat_errors", LINE_W'(stat_errors), LINE_W'(3));
`endif

      @(posedge clock); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
